// File: rtl/dct_pkg.sv
// Shared types and the 8x8 DCT-II coefficient table (Q0.32, signed) used by the row sequencer.
package dct_pkg;

  localparam int DCT_N = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} dct_state_e;

  // round(alpha(u) * cos(k*pi/16) * 2^32); CD is the DC row (sqrt(1/8)), equal to C4.
  localparam logic signed [31:0] CD = 32'sd1518500250;
  localparam logic signed [31:0] C1 = 32'sd2106220352;
  localparam logic signed [31:0] C2 = 32'sd1984016189;
  localparam logic signed [31:0] C3 = 32'sd1785567396;
  localparam logic signed [31:0] C4 = 32'sd1518500250;
  localparam logic signed [31:0] C5 = 32'sd1193077991;
  localparam logic signed [31:0] C6 = 32'sd821806413;
  localparam logic signed [31:0] C7 = 32'sd418953276;

  // Index is row*8 + lane.
  localparam logic signed [31:0] DCT_COEF [0:63] = '{
    CD,  CD,  CD,  CD,  CD,  CD,  CD,  CD,
    C1,  C3,  C5,  C7, -C7, -C5, -C3, -C1,
    C2,  C6, -C6, -C2, -C2, -C6,  C6,  C2,
    C3, -C7, -C1, -C5,  C5,  C1,  C7, -C3,
    C4, -C4, -C4,  C4,  C4, -C4, -C4,  C4,
    C5, -C1,  C7,  C3, -C3, -C7,  C1, -C5,
    C6, -C2,  C2, -C6, -C6,  C2, -C2,  C6,
    C7, -C5,  C3, -C1,  C1, -C3,  C5, -C7
  };

  // Inverse transform reads the transposed matrix: lane x of row u gets C[x][u].
  function automatic logic [5:0] coef_idx(input logic [2:0] row, input logic [2:0] lane,
                                          input logic inverse);
    return inverse ? {lane, row} : {row, lane};
  endfunction

endpackage

// File: rtl/dct_coeff_rom.sv
// Combinational coefficient row lookup; 'inverse' selects the transposed matrix.
module dct_coeff_rom
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                  row,
  input  logic                        inverse,
  output logic [DATA_WIDTH*DCT_N-1:0] coeff
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("dct_coeff_rom: coefficient table is built for DATA_WIDTH=32");
  end

  always_comb begin
    coeff = '0;
    for (int x = 0; x < DCT_N; x++)
      coeff[x*DATA_WIDTH +: DATA_WIDTH] = DCT_COEF[coef_idx(row, 3'(x), inverse)];
  end

endmodule

// File: rtl/dct_row_sched.sv
// Sequences one 8-sample vector through the shared 8-tap MAC (eight coefficient rows),
// collects the results and streams them out with backpressure.
module dct_row_sched
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*DCT_N-1:0] in_data,
  input  logic                        in_inverse,
  output logic [DATA_WIDTH*DCT_N-1:0] mac_data,
  output logic [DATA_WIDTH*DCT_N-1:0] mac_coeff,
  input  logic [DATA_WIDTH-1:0]       mac_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [2:0]                  out_index,
  output logic                        out_last,
  output logic                        busy
);

  localparam int VW = DATA_WIDTH * DCT_N;

  if (DATA_DEPTH != DCT_N) begin : g_bad_depth
    $error("dct_row_sched: DATA_DEPTH must be 8");
  end

  dct_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [VW-1:0]         samp_q, samp_d;
  logic                  inv_q, inv_d;
  logic [DATA_WIDTH-1:0] buf_q [DCT_N];
  logic [DATA_WIDTH-1:0] buf_d [DCT_N];

  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [2:0]            out_index_q, out_index_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [VW-1:0]         mac_data_q, mac_data_d;
  logic [VW-1:0]         mac_coeff_q, mac_coeff_d;
  logic [VW-1:0]         rom_coeff;

  // Looked up with the next-cycle row so the operand registers line up with ISSUE.
  dct_coeff_rom #(.DATA_WIDTH(DATA_WIDTH)) u_rom (
    .row     (cnt_d),
    .inverse (inv_d),
    .coeff   (rom_coeff)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    inv_d   = inv_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        samp_d  = in_data;
        inv_d   = in_inverse;
        cnt_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        // MAC output is one cycle behind the row being issued.
        if (cnt_q != 3'd0) buf_d[cnt_q - 3'd1] = mac_result;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = WAIT;
      end
      WAIT: begin
        buf_d[DCT_N-1] = mac_result;
        cnt_d          = '0;
        state_d        = OUT;
      end
      OUT: if (out_ready) begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == OUT);
    out_index_d = out_valid_d ? cnt_d : 3'd0;
    out_last_d  = out_valid_d && (cnt_d == 3'd7);
    out_data_d  = out_valid_d ? buf_d[cnt_d] : '0;
    mac_data_d  = (state_d == ISSUE) ? samp_d : '0;
    mac_coeff_d = (state_d == ISSUE) ? rom_coeff : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      samp_q      <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      mac_data_q  <= '0;
      mac_coeff_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      samp_q      <= samp_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      mac_data_q  <= mac_data_d;
      mac_coeff_q <= mac_coeff_d;
    end
  end

  // Result buffer is always overwritten before it is read, so it carries no reset.
  always_ff @(posedge clk) buf_q <= buf_d;

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign mac_data  = mac_data_q;
  assign mac_coeff = mac_coeff_q;

endmodule

// File: tb/tb_dct_row_sched.sv
// Randomized bench for dct_row_sched: MAC modelled with 1-cycle latency, outputs checked
// against a real-arithmetic DCT reference.
module tb_dct_row_sched;
  localparam int DW = 32;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_inverse, out_ready;
  logic            in_ready, out_valid, out_last, busy;
  logic [DW*N-1:0] in_data, mac_data, mac_coeff;
  logic [DW-1:0]   mac_result, out_data;
  logic [2:0]      out_index;

  int     n_tests = 0, n_fail = 0, cyc = 0;
  bit     stub = 1'b0;
  int     s [N];
  longint expv [N];
  longint got [N];
  int     hs_cyc, first_cyc, last_cyc;

  dct_row_sched #(.DATA_WIDTH(DW), .DATA_DEPTH(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inverse(in_inverse), .mac_data(mac_data), .mac_coeff(mac_coeff),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-tap MAC, upper word of the product sum; stub mode tags each row by its lane-1 coefficient.
  function automatic logic [DW-1:0] mac_fn(input logic [DW*N-1:0] d, input logic [DW*N-1:0] c);
    longint acc;
    acc = 0;
    if (stub) return c[2*DW-1:DW] ^ 32'h0F0F_0F0F;
    for (int x = 0; x < N; x++)
      acc += longint'($signed(d[x*DW +: DW])) * longint'($signed(c[x*DW +: DW]));
    return DW'(acc >>> DW);
  endfunction

  always @(posedge clk) mac_result <= mac_fn(mac_data, mac_coeff);

  function automatic longint cref(input int u, input int x);
    real a, v;
    a = (u == 0) ? $sqrt(0.125) : 0.5;
    v = a * $cos(real'((2*x + 1) * u) * 3.14159265358979323846 / 16.0) * 4294967296.0;
    return longint'($rtoi(v + ((v >= 0.0) ? 0.5 : -0.5)));
  endfunction

  // Coefficient applied to lane x while row u is issued.
  function automatic longint lane_coef(input bit inv, input int u, input int x);
    return inv ? cref(x, u) : cref(u, x);
  endfunction

  task automatic build_exp(input bit inv);
    longint acc;
    for (int u = 0; u < N; u++) begin
      acc = 0;
      for (int x = 0; x < N; x++) acc += longint'(s[x]) * lane_coef(inv, u, x);
      expv[u] = acc >>> 32;
    end
  endtask

  task automatic chk(input string tag, input longint got_v, input longint exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  task automatic rand_samples();
    for (int x = 0; x < N; x++) s[x] = int'($urandom) >>> 11;
  endtask

  task automatic load(input bit inv);
    for (int x = 0; x < N; x++) in_data[x*DW +: DW] = s[x];
    in_inverse = inv;
  endtask

  task automatic send(input bit inv, input bit hold);
    int n;
    n = 0;
    load(inv);
    in_valid = 1'b1;
    while (!in_ready && n < 64) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", longint'(in_ready), 1);
    @(posedge clk); #1;
    hs_cyc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic collect(input int stall_u, input int stall_n);
    int n;
    logic [DW-1:0] d0;
    for (int u = 0; u < N; u++) begin
      n = 0;
      while (!out_valid && n < 64) begin @(posedge clk); #1; n++; end
      if (u == 0) first_cyc = cyc;
      chk("out_valid_wait", longint'(out_valid), 1);
      chk("in_ready_low", longint'(in_ready), 0);
      if (u == stall_u) begin
        d0 = out_data;
        repeat (stall_n) begin
          @(posedge clk); #1;
          chk("stall_data", longint'(out_data), longint'(d0));
          chk("stall_index", longint'(out_index), longint'(u));
          chk("stall_in_ready", longint'(in_ready), 0);
        end
      end
      got[u] = longint'($signed(out_data));
      chk("out_data", got[u], expv[u]);
      chk("out_index", longint'(out_index), longint'(u));
      chk("out_last", longint'(out_last), longint'(u == N-1));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    last_cyc = cyc;
    chk("in_ready_after", longint'(in_ready), 1);
  endtask

  task automatic run_vec(input bit inv, input int stall_u, input int stall_n);
    build_exp(inv);
    send(inv, 1'b0);
    collect(stall_u, stall_n);
    chk("first_latency", longint'(first_cyc - hs_cyc), 9);
  endtask

  initial begin
    logic [DW-1:0] tag;
    bit inv2;
    reset = 1'b1; in_valid = 1'b0; in_inverse = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_index", longint'(out_index), 0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_mac_data", longint'(|mac_data), 0);
    chk("rst_mac_coeff", longint'(|mac_coeff), 0);

    // Forward DC
    for (int x = 0; x < N; x++) s[x] = 100;
    run_vec(1'b0, -1, 0);
    chk("dc_out0", got[0], 282);
    for (int u = 1; u < N; u++) chk("dc_ac_small", longint'(got[u] == 0 || got[u] == -1), 1);

    // Inverse impulse
    for (int x = 0; x < N; x++) s[x] = (x == 0) ? 1000 : 0;
    run_vec(1'b1, -1, 0);
    for (int u = 0; u < N; u++) chk("impulse_out", got[u], 353);

    // Backpressure at index 3
    rand_samples();
    run_vec(1'b0, 3, 5);

    // Back-to-back with in_valid held high
    rand_samples();
    build_exp(1'b0);
    send(1'b0, 1'b1);
    rand_samples();
    inv2 = 1'b1;
    load(inv2);
    collect(-1, 0);
    @(posedge clk); #1;
    chk("b2b_accept_busy", longint'(busy), 1);
    chk("b2b_accept_ready", longint'(in_ready), 0);
    hs_cyc = cyc;
    chk("b2b_gap", longint'(hs_cyc - last_cyc), 1);
    in_valid = 1'b0;
    build_exp(inv2);
    collect(-1, 0);
    chk("b2b_latency", longint'(first_cyc - hs_cyc), 9);

    // Reset mid-ISSUE at cnt=4
    rand_samples();
    inv2 = 1'($urandom_range(0, 1));
    send(inv2, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    for (int x = 0; x < N; x++)
      chk("issue_row4_coef", longint'($signed(mac_coeff[x*DW +: DW])), lane_coef(inv2, 4, x));
    chk("issue_data", longint'(mac_data == in_data), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_mac_data", longint'(|mac_data), 0);
    chk("midrst_mac_coeff", longint'(|mac_coeff), 0);
    rand_samples();
    run_vec(1'b0, -1, 0);

    // Random vectors with random stalls
    for (int i = 0; i < 6; i++) begin
      rand_samples();
      run_vec(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    // Row-tagging MAC stub: buf[u] must hold the result for row u
    stub = 1'b1;
    for (int m = 0; m < 2; m++) begin
      rand_samples();
      for (int u = 0; u < N; u++) begin
        tag = DW'(lane_coef(m[0], u, 1)) ^ 32'h0F0F_0F0F;
        expv[u] = longint'($signed(tag));
      end
      send(m[0], 1'b0);
      collect(-1, 0);
    end
    stub = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
